// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared encodings for the memory access unit: request size
//               codes and the controller state type.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_merge.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_merge
// Description : Combinational little-endian lane logic.
//               Store path: replaces the addressed byte/half of base_word
//               with the low bits of wdata (word size passes wdata through).
//               Load path: extracts the addressed byte/half of rd_word,
//               right-justified and sign- or zero-extended.
// Ports       : base_word  - word captured from memory (store merge)
//               rd_word    - word read from memory (load extract)
//               lane       - byte address bits [1:0]
//               size       - SIZE_BYTE / SIZE_HALF / SIZE_WORD
//               wdata      - right-justified store data
//               is_signed  - sign-extend loads when set
//               merged     - word to be written back
//               load_value - extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_merge
    import mem_access_pkg::*;
(
    input  logic [31:0] base_word,
    input  logic [31:0] rd_word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic        is_signed,
    output logic [31:0] merged,
    output logic [31:0] load_value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        merged = base_word;
        case (size)
            SIZE_BYTE: merged[{lane, 3'b000} +: 8]     = wdata[7:0];
            SIZE_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default:   merged = wdata;
        endcase
    end

    always_comb begin
        byte_sel   = rd_word[{lane, 3'b000} +: 8];
        half_sel   = rd_word[{lane[1], 4'b0000} +: 16];
        case (size)
            SIZE_BYTE: load_value = {{24{is_signed & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_value = {{16{is_signed & half_sel[15]}}, half_sel};
            default:   load_value = rd_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store initiator for a word-addressed data memory with
//               combinational read and posedge write. Sub-word stores use a
//               read-modify-write; sub-word loads are extracted and extended.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               ReqValid/ReqReady             - request handshake
//               ReqWrite/ReqSize/ReqSigned    - request type
//               ReqAddr/ReqWData              - byte address, store data
//               RespValid/RespReady           - response handshake
//               RespRData/RespErr             - load data, error flag
//               MemAddress/MemWriteData       - memory word address, data
//               MemRead/MemWrite              - memory strobes
//               MemReadData                   - memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespRData,
    output logic        RespErr,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemReadData
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

    state_t      state;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] cap_word;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        in_err;
    logic [31:0] merged;
    logic [31:0] load_value;

    // Request legality is judged on the live inputs so the accept cycle can
    // route straight to RESP without touching memory.
    assign in_err = (ReqSize == 2'b11)
                 || ((ReqSize == SIZE_HALF) && ReqAddr[0])
                 || ((ReqSize == SIZE_WORD) && (ReqAddr[1:0] != 2'b00))
                 || (ReqAddr >= ADDR_LIMIT);

    mem_lane_merge u_lane (
        .base_word  (cap_word),
        .rd_word    (MemReadData),
        .lane       (req_addr[1:0]),
        .size       (req_size),
        .wdata      (req_wdata),
        .is_signed  (req_signed),
        .merged     (merged),
        .load_value (load_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_write  <= 1'b0;
            req_size   <= SIZE_BYTE;
            req_signed <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            cap_word   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        req_write  <= ReqWrite;
                        req_size   <= ReqSize;
                        req_signed <= ReqSigned;
                        req_addr   <= ReqAddr;
                        req_wdata  <= ReqWData;
                        resp_rdata <= '0;
                        resp_err   <= in_err;
                        if (in_err)
                            state <= RESP;
                        else if (ReqWrite && (ReqSize == SIZE_WORD))
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                READ: begin
                    cap_word <= MemReadData;
                    if (req_write) begin
                        state <= WRITE;
                    end else begin
                        resp_rdata <= load_value;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    state <= RESP;
                end
                RESP: begin
                    if (RespReady)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode from state alone so an async reset removes them at once.
    assign ReqReady     = (state == IDLE);
    assign RespValid    = (state == RESP);
    assign MemRead      = (state == READ);
    assign MemWrite     = (state == WRITE);
    assign MemAddress   = {req_addr[31:2], 2'b00};
    assign MemWriteData = (state == WRITE) ? merged : 32'h0;
    assign RespRData    = resp_rdata;
    assign RespErr      = resp_err;

endmodule
`default_nettype wire
